fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data width of each requester and of the FIFO write port.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 Parameter MAX_BURST, default 8: maximum number of beats per grant, legal range 1..255.
REQ-004 i_clk  in  1  single clock; all logic is on the rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req  in  NREQ  per-requester beat-valid.
REQ-007 i_last  in  NREQ  per-requester end-of-packet marker, qualified by i_req.
REQ-008 i_wdata  in  NREQ*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-009 i_fifo_full  in  1  full flag from the downstream sync FIFO.
REQ-010 i_flush  in  1  synchronous flush request.
REQ-011 o_gnt  out  NREQ  one-hot beat-accept strobe.
REQ-012 o_push  out  1  push to the FIFO.
REQ-013 o_wdata  out  WIDTH  data to the FIFO.
REQ-014 o_flush  out  1  flush to the FIFO; equals i_flush combinationally.
REQ-015 o_owner  out  clog2(NREQ)  index of the current owner.
REQ-016 o_busy  out  1  high while in the BUSY state.
REQ-017 o_burst_err  out  1  sticky flag: a burst was cut at MAX_BURST.

Function
REQ-018 The FSM SHALL have two states: IDLE and BUSY.
REQ-019 In IDLE with any i_req high, the block SHALL select the winner round-robin, starting at the priority pointer, then register o_owner and enter BUSY on the next edge; o_push is 0 during IDLE.
REQ-020 In BUSY, o_push SHALL equal i_req[o_owner] AND NOT i_fifo_full AND NOT i_flush, combinationally.
REQ-021 o_gnt[o_owner] SHALL equal o_push, and all other o_gnt bits SHALL be 0; o_wdata SHALL be the owner's data, as a combinational mux.
REQ-022 An accepted beat SHALL increment the 8-bit beat counter, which is cleared on every entry to BUSY.
REQ-023 On an accepted beat with i_last[o_owner] high, the FSM SHALL return to IDLE, and the pointer SHALL be set to (o_owner+1) mod NREQ.
REQ-024 On an accepted beat that brings the beat count to MAX_BURST without i_last, the FSM SHALL return to IDLE, advance the pointer as in REQ-023, and set o_burst_err.
REQ-025 If i_last and the MAX_BURST cut occur on the same beat, the beat SHALL be treated as a normal last beat and SHALL NOT set the error.
REQ-026 While i_fifo_full is high or i_req[o_owner] is low in BUSY, the block SHALL hold its state, owner and count, with no timeout.
REQ-027 Requests from non-owners SHALL be ignored during BUSY.
REQ-028 Every packet SHALL cost exactly one IDLE bubble cycle between grants.
REQ-029 i_flush SHALL win over all other events and, on the next edge, force IDLE, the pointer to 0, the count to 0, o_owner to 0, and o_burst_err to 0.

Reset
REQ-030 Reset SHALL set the state to IDLE, the pointer to 0, o_owner to 0, the count to 0, and o_burst_err to 0; o_push and o_gnt are therefore 0 and o_busy is 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately, with no further push.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, BUSY=1), the clog2 function, and the beat-counter width constant.
REQ-033 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and pointer; outputs: one-hot winner, index, and a valid flag).

Verification
REQ-034 Reset-release scenario: after reset, i_req=4'b1111 with i_last=4'b1111 held -> grants go to 0,1,2,3,0, one beat each, with o_push on every second cycle.
REQ-035 Stall scenario: requester 2 sends a 3-beat packet with i_fifo_full high for 4 cycles after beat 1 -> o_push stays low for exactly 4 cycles, o_owner stays 2, and beats 2-3 follow once full drops.
REQ-036 Burst-cap scenario: MAX_BURST=8 and requester 1 sends 10 beats without i_last -> 8 pushes, o_burst_err=1, and the next grant goes to requester 2 if it is requesting.
REQ-037 Flush scenario: i_flush is asserted on the 2nd beat of requester 3 -> no push that cycle, then IDLE, o_owner=0, o_burst_err=0, and o_flush pulses for 1 cycle.
REQ-038 Reset-mid-packet scenario: i_rst_n is dropped in BUSY -> o_push=0 asynchronously, and after release the first grant goes to requester 0.
REQ-039 Last-at-cap scenario: MAX_BURST=4 and a packet whose 4th beat has i_last=1 -> o_burst_err stays 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so an index port always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the arbiter, bundled as one port.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned OWN_W = clog2(NREQ);

  logic [NREQ-1:0]       i_req;
  logic [NREQ-1:0]       i_last;
  logic [NREQ*WIDTH-1:0] i_wdata;
  logic                  i_fifo_full;
  logic                  i_flush;
  logic [NREQ-1:0]       o_gnt;
  logic                  o_push;
  logic [WIDTH-1:0]      o_wdata;
  logic                  o_flush;
  logic [OWN_W-1:0]      o_owner;
  logic                  o_busy;
  logic                  o_burst_err;

  modport slave (
    input  i_req, i_last, i_wdata, i_fifo_full, i_flush,
    output o_gnt, o_push, o_wdata, o_flush, o_owner, o_busy, o_burst_err
  );

  modport master (
    output i_req, i_last, i_wdata, i_fifo_full, i_flush,
    input  o_gnt, o_push, o_wdata, o_flush, o_owner, o_busy, o_burst_err
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned k;
      k = 32'(i_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!o_valid && i_req[k]) begin
        o_valid  = 1'b1;
        o_idx    = IDX_W'(k);
        o_gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter in front of a sync FIFO write port; an owner
// keeps the port until its last beat or the burst cap, then one idle bubble.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = clog2(NREQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [NREQ-1:0]    r_owner_oh;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_burst_err;

  logic [NREQ-1:0]    w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic               w_busy;
  logic               w_push;
  logic               w_last;
  logic               w_cap;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]   w_wdata;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (bus.i_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_busy    = (r_state == ST_BUSY);
  assign w_push    = w_busy & bus.i_req[r_owner] & ~bus.i_fifo_full & ~bus.i_flush;
  assign w_last    = bus.i_last[r_owner];
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_cap     = (w_cnt_nxt == CNT_W'(MAX_BURST));
  assign w_ptr_nxt = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Owner data mux.
  always_comb begin
    w_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (r_owner == IDX_W'(k)) w_wdata = bus.i_wdata[k*WIDTH +: WIDTH];
    end
  end

  assign bus.o_push      = w_push;
  assign bus.o_gnt       = r_owner_oh & {NREQ{w_push}};
  assign bus.o_wdata     = w_wdata;
  assign bus.o_flush     = bus.i_flush;
  assign bus.o_owner     = r_owner;
  assign bus.o_busy      = w_busy;
  assign bus.o_burst_err = r_burst_err;

  // Flush outranks everything; a last beat at the cap is a clean end, not an error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_owner_oh  <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_burst_err <= 1'b0;
    end else if (bus.i_flush) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_owner_oh  <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_burst_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state    <= ST_BUSY;
            r_owner    <= w_pick_idx;
            r_owner_oh <= w_pick_oh;
            r_cnt      <= '0;
          end
        end
        ST_BUSY: begin
          if (w_push) begin
            r_cnt <= w_cnt_nxt;
            if (w_last || w_cap) begin
              r_state <= ST_IDLE;
              r_ptr   <= w_ptr_nxt;
            end
            if (w_cap && !w_last) r_burst_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: MAX_BURST=8 main instance, MAX_BURST=4 for the last-at-cap case.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic        full;
  logic        flush;
  logic [63:0] wdata;
  int unsigned bcnt [4];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb [$];

  fifo_wr_arbiter_if #(.WIDTH(16), .NREQ(4)) bus8 ();
  fifo_wr_arbiter_if #(.WIDTH(16), .NREQ(4)) bus4 ();

  assign bus8.i_req = req;   assign bus4.i_req = req;
  assign bus8.i_last = last; assign bus4.i_last = last;
  assign bus8.i_wdata = wdata; assign bus4.i_wdata = wdata;
  assign bus8.i_fifo_full = full; assign bus4.i_fifo_full = full;
  assign bus8.i_flush = flush; assign bus4.i_flush = flush;

  fifo_wr_arbiter #(.WIDTH(16), .NREQ(4), .MAX_BURST(8)) dut8 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus8.slave)
  );
  fifo_wr_arbiter #(.WIDTH(16), .NREQ(4), .MAX_BURST(4)) dut4 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each requester presents {k+1, beat number}; the beat advances when it is granted.
  always_comb begin
    wdata = '0;
    for (int k = 0; k < 4; k++) wdata[k*16 +: 16] = {4'(k + 1), 12'(bcnt[k])};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) bcnt[k] <= 0;
    end else begin
      for (int k = 0; k < 4; k++) if (bus8.o_gnt[k]) bcnt[k] <= bcnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ent(input int own, input int beat);
    return {8'(own), 8'h00, 4'(own + 1), 12'(beat)};
  endfunction

  // Scoreboard: every push of the main instance must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && bus8.o_push) begin
      if (sb.size() == 0) chk("sb_unexpected_push", 32'd1, 32'd0);
      else chk("sb_push", {8'(bus8.o_owner), 8'h00, bus8.o_wdata}, sb.pop_front());
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input logic push, input logic busy, input int own);
    @(negedge clk);
    chk({tag, ":push"}, 32'(bus8.o_push), 32'(push));
    chk({tag, ":busy"}, 32'(bus8.o_busy), 32'(busy));
    chk({tag, ":gnt"}, 32'(bus8.o_gnt), push ? (32'd1 << own) : 32'd0);
    if (busy) chk({tag, ":owner"}, 32'(bus8.o_owner), 32'(own));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; last = '0; full = 1'b0; flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst:push", 32'(bus8.o_push), 32'd0);
    chk("rst:gnt", 32'(bus8.o_gnt), 32'd0);
    chk("rst:busy", 32'(bus8.o_busy), 32'd0);
    chk("rst:owner", 32'(bus8.o_owner), 32'd0);
    chk("rst:err", 32'(bus8.o_burst_err), 32'd0);
    chk("rst:busy4", 32'(bus4.o_busy), 32'd0);
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    chk({tag, ":sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; last = '0; full = 1'b0; flush = 1'b0;
    nxt();

    // All four request single-beat packets: 0,1,2,3,0 with a bubble between each.
    do_reset();
    req = 4'hF; last = 4'hF;
    sb.push_back(ent(0, 0)); sb.push_back(ent(1, 0)); sb.push_back(ent(2, 0));
    sb.push_back(ent(3, 0)); sb.push_back(ent(0, 1));
    for (int c = 0; c < 10; c++) begin
      chk_cyc("rr", 1'(c % 2), 1'(c % 2), (c / 2) % 4);
      nxt();
    end
    req = '0; last = '0;
    chk_cyc("rr_end", 1'b0, 1'b0, 0);
    drain("rr");
    nxt();

    // Requester 2, three beats, FIFO full for four cycles after beat 1.
    do_reset();
    req = 4'b0100;
    sb.push_back(ent(2, 0)); sb.push_back(ent(2, 1)); sb.push_back(ent(2, 2));
    chk_cyc("stall_c0", 1'b0, 1'b0, 0); nxt();
    req = 4'hF;
    chk_cyc("stall_b1", 1'b1, 1'b1, 2); nxt();
    full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk_cyc("stall_hold", 1'b0, 1'b1, 2); nxt();
    end
    full = 1'b0;
    chk_cyc("stall_b2", 1'b1, 1'b1, 2); nxt();
    last = 4'hF;
    chk_cyc("stall_b3", 1'b1, 1'b1, 2); nxt();
    req = '0; last = '0;
    chk_cyc("stall_end", 1'b0, 1'b0, 0);
    drain("stall");
    nxt();

    // Requester 1 without last: cut after 8 beats, then requester 2 wins.
    do_reset();
    req = 4'b0010;
    for (int b = 0; b < 8; b++) sb.push_back(ent(1, b));
    sb.push_back(ent(2, 0));
    chk_cyc("cap_c0", 1'b0, 1'b0, 0); nxt();
    req = 4'b0110;
    for (int b = 0; b < 8; b++) begin
      chk_cyc("cap_beat", 1'b1, 1'b1, 1);
      chk("cap_err_lo", 32'(bus8.o_burst_err), 32'd0);
      nxt();
    end
    last = 4'b0100;
    chk_cyc("cap_bubble", 1'b0, 1'b0, 0);
    chk("cap_err_set", 32'(bus8.o_burst_err), 32'd1);
    nxt();
    chk_cyc("cap_next", 1'b1, 1'b1, 2);
    chk("cap_err_sticky", 32'(bus8.o_burst_err), 32'd1);
    nxt();
    req = '0; last = '0;
    chk_cyc("cap_end", 1'b0, 1'b0, 0);
    drain("cap");
    nxt();

    // Flush on requester 3's second beat, with the error flag still set.
    req = 4'b1000;
    sb.push_back(ent(3, 0)); sb.push_back(ent(0, 0));
    chk_cyc("fl_c0", 1'b0, 1'b0, 0); nxt();
    chk_cyc("fl_b1", 1'b1, 1'b1, 3); nxt();
    flush = 1'b1;
    chk_cyc("fl_b2", 1'b0, 1'b1, 3);
    chk("fl_oflush", 32'(bus8.o_flush), 32'd1);
    nxt();
    flush = 1'b0; req = 4'b1001; last = 4'b1001;
    chk_cyc("fl_after", 1'b0, 1'b0, 0);
    chk("fl_owner", 32'(bus8.o_owner), 32'd0);
    chk("fl_err", 32'(bus8.o_burst_err), 32'd0);
    chk("fl_oflush_lo", 32'(bus8.o_flush), 32'd0);
    nxt();
    chk_cyc("fl_ptr0", 1'b1, 1'b1, 0); nxt();
    req = '0; last = '0;
    chk_cyc("fl_end", 1'b0, 1'b0, 0);
    drain("flush");
    nxt();

    // Reset dropped while requester 1 is mid-packet.
    do_reset();
    req = 4'b0010;
    sb.push_back(ent(1, 0)); sb.push_back(ent(1, 1)); sb.push_back(ent(0, 0));
    chk_cyc("rmp_c0", 1'b0, 1'b0, 0); nxt();
    chk_cyc("rmp_b1", 1'b1, 1'b1, 1); nxt();
    chk_cyc("rmp_b2", 1'b1, 1'b1, 1); nxt();
    rst_n = 1'b0;
    #1;
    chk("rmp_async_push", 32'(bus8.o_push), 32'd0);
    chk("rmp_async_busy", 32'(bus8.o_busy), 32'd0);
    @(posedge clk);
    nxt();
    rst_n = 1'b1; req = 4'hF; last = 4'hF;
    chk_cyc("rmp_idle", 1'b0, 1'b0, 0); nxt();
    chk_cyc("rmp_first", 1'b1, 1'b1, 0); nxt();
    req = '0; last = '0;
    chk_cyc("rmp_end", 1'b0, 1'b0, 0);
    drain("rmp");
    nxt();

    // Four-beat packet whose last beat lands on the cap of the MAX_BURST=4 instance.
    do_reset();
    req = 4'b0001;
    for (int b = 0; b < 4; b++) sb.push_back(ent(0, b));
    chk_cyc("lac_c0", 1'b0, 1'b0, 0); nxt();
    for (int b = 0; b < 4; b++) begin
      last = (b == 3) ? 4'b0001 : 4'b0000;
      chk_cyc("lac_beat", 1'b1, 1'b1, 0);
      chk("lac_push4", 32'(bus4.o_push), 32'd1);
      chk("lac_owner4", 32'(bus4.o_owner), 32'd0);
      nxt();
    end
    req = '0; last = '0;
    chk_cyc("lac_end", 1'b0, 1'b0, 0);
    chk("lac_busy4", 32'(bus4.o_busy), 32'd0);
    chk("lac_err4", 32'(bus4.o_burst_err), 32'd0);
    chk("lac_err8", 32'(bus8.o_burst_err), 32'd0);
    drain("lac");
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
